// File: rtl/dispense_cmd_initiator.sv
// Command-issuing end of the parallel motor-command interface: latches one request,
// drives the data lines and runs a 4-phase handshake. Optional macro: HS_RETRY_EN.
module dispense_cmd_initiator #(
  parameter int unsigned SETUP_CYCLES     = 4,
  parameter int unsigned TIMEOUT_CYCLES   = 2000000,
  parameter int unsigned TEST_HOLD_CYCLES = 1040000,
  parameter int unsigned CNT_W            = 21
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_mode,
  input  logic [2:0] req_test,
  input  logic [1:0] req_amount,
  input  logic       handshake_in,
  output logic [2:0] cmd_state,
  output logic [1:0] cmd_amount,
  output logic       cmd_flag,
  output logic       busy,
  output logic       done,
  output logic       timeout
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETUP   = 3'd1,
    S_ASSERT  = 3'd2,
    S_RELEASE = 3'd3,
    S_ABORT   = 3'd4,
    S_TEST    = 3'd5
  } state_e;

  // Counter value seen in the last cycle of each timed window
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(TEST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hs_meta_q, hs_s_q;
  logic [2:0]       test_q, test_d;
  logic [1:0]       amount_q, amount_d;
  logic             done_d, timeout_d;
  logic             req_ready_q, busy_q, done_q, timeout_q, cmd_flag_q;
  logic [2:0]       cmd_state_q;
  logic [1:0]       cmd_amount_q;
`ifdef HS_RETRY_EN
  logic             retry_q, retry_d;
`endif

  assign req_ready  = req_ready_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign timeout    = timeout_q;
  assign cmd_flag   = cmd_flag_q;
  assign cmd_state  = cmd_state_q;
  assign cmd_amount = cmd_amount_q;

  // Two-flop synchronizer for the responder handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_meta_q <= 1'b0;
      hs_s_q    <= 1'b0;
    end else begin
      hs_meta_q <= handshake_in;
      hs_s_q    <= hs_meta_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    test_d    = test_q;
    amount_d  = amount_q;
    done_d    = 1'b0;
    timeout_d = 1'b0;
`ifdef HS_RETRY_EN
    retry_d   = retry_q;
`endif
    case (state_q)
      S_IDLE: begin
`ifdef HS_RETRY_EN
        retry_d = 1'b0;
`endif
        if (req_valid && req_ready_q) begin
          test_d   = req_test;
          amount_d = req_amount;
          state_d  = req_mode ? S_SETUP : S_TEST;
        end
      end
      S_SETUP: begin
        if ((cnt_q >= SETUP_LAST) && !hs_s_q) begin
          state_d = S_ASSERT;
        end else if (cnt_q >= TO_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_ABORT;
        end
      end
      S_ASSERT: begin
        // A handshake seen in the expiry cycle takes priority over the timeout
        if (hs_s_q) begin
          state_d = S_RELEASE;
        end else if (cnt_q >= TO_LAST) begin
`ifdef HS_RETRY_EN
          if (!retry_q) begin
            retry_d = 1'b1;
            state_d = S_SETUP;
          end else begin
            timeout_d = 1'b1;
            state_d   = S_ABORT;
          end
`else
          timeout_d = 1'b1;
          state_d   = S_ABORT;
`endif
        end
      end
      S_RELEASE: begin
        if (!hs_s_q) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (cnt_q >= TO_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_ABORT: state_d = S_IDLE;
      S_TEST: begin
        if (cnt_q >= HOLD_LAST) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  // State, counter, latched request and outputs registered from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      test_q       <= 3'b000;
      amount_q     <= 2'b00;
      req_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      cmd_flag_q   <= 1'b0;
      cmd_state_q  <= 3'b000;
      cmd_amount_q <= 2'b00;
`ifdef HS_RETRY_EN
      retry_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      test_q       <= test_d;
      amount_q     <= amount_d;
      req_ready_q  <= (state_d == S_IDLE);
      busy_q       <= (state_d != S_IDLE);
      done_q       <= done_d;
      timeout_q    <= timeout_d;
      cmd_flag_q   <= (state_d == S_ASSERT);
      cmd_state_q  <= (state_d == S_TEST) ? test_d : 3'b000;
      cmd_amount_q <= ((state_d == S_SETUP) || (state_d == S_ASSERT) ||
                       (state_d == S_RELEASE)) ? amount_d : 2'b00;
`ifdef HS_RETRY_EN
      retry_q      <= retry_d;
`endif
    end
  end

endmodule

// File: tb/tb_dispense_cmd_initiator.sv
// Bench for dispense_cmd_initiator: directed and random requests against a phase-level
// reference model of the handshake timeline (honours HS_RETRY_EN).
module tb_dispense_cmd_initiator;

  localparam int SETUP = 4;
  localparam int TOUT  = 64;
  localparam int HOLD  = 16;
  localparam int NCYC  = 400;
  localparam int NEVER = 1000000;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic       req_mode;
  logic [2:0] req_test;
  logic [1:0] req_amount;
  logic       handshake_in;
  logic [2:0] cmd_state;
  logic [1:0] cmd_amount;
  logic       cmd_flag;
  logic       busy;
  logic       done;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  // Per-cycle expectations; cycle 1 is the first cycle after the accepting edge
  logic       e_flag [NCYC];
  logic [1:0] e_amt  [NCYC];
  logic [2:0] e_st   [NCYC];
  logic       e_busy [NCYC];
  logic       e_done [NCYC];
  logic       e_to   [NCYC];
  int         last_cyc;
  int         hs_up;
  int         hs_dn;

  dispense_cmd_initiator #(
    .SETUP_CYCLES(SETUP), .TIMEOUT_CYCLES(TOUT), .TEST_HOLD_CYCLES(HOLD), .CNT_W(21)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_mode(req_mode), .req_test(req_test), .req_amount(req_amount),
    .handshake_in(handshake_in), .cmd_state(cmd_state), .cmd_amount(cmd_amount),
    .cmd_flag(cmd_flag), .busy(busy), .done(done), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_cycle(input int c);
    check($sformatf("flag c%0d", c),    8'(cmd_flag),   8'(e_flag[c]));
    check($sformatf("amount c%0d", c),  8'(cmd_amount), 8'(e_amt[c]));
    check($sformatf("state c%0d", c),   8'(cmd_state),  8'(e_st[c]));
    check($sformatf("ready c%0d", c),   8'(req_ready),  8'(!e_busy[c]));
    check($sformatf("busy c%0d", c),    8'(busy),       8'(e_busy[c]));
    check($sformatf("done c%0d", c),    8'(done),       8'(e_done[c]));
    check($sformatf("timeout c%0d", c), 8'(timeout),    8'(e_to[c]));
  endtask

  task automatic check_reset(input string tag);
    check({tag, " flag"},    8'(cmd_flag),   8'd0);
    check({tag, " state"},   8'(cmd_state),  8'd0);
    check({tag, " amount"},  8'(cmd_amount), 8'd0);
    check({tag, " ready"},   8'(req_ready),  8'd1);
    check({tag, " busy"},    8'(busy),       8'd0);
    check({tag, " done"},    8'(done),       8'd0);
    check({tag, " timeout"}, 8'(timeout),    8'd0);
  endtask

  // ---------------- reference model ----------------
  function automatic logic hs_seen(input int c);
    return (c - 2 >= hs_up) && (c - 2 < hs_dn);
  endfunction

  function automatic int first_lvl(input int lo, input int hi, input logic lvl);
    for (int c = lo; c <= hi; c++) if (hs_seen(c) == lvl) return c;
    return -1;
  endfunction

  task automatic clear_exp();
    for (int c = 0; c < NCYC; c++) begin
      e_flag[c] = 1'b0; e_amt[c] = 2'b00; e_st[c] = 3'b000;
      e_busy[c] = 1'b0; e_done[c] = 1'b0; e_to[c] = 1'b0;
    end
  endtask

  task automatic fill(input int lo, input int hi, input logic fl, input logic [1:0] am,
                      input logic [2:0] st);
    for (int c = lo; c <= hi; c++) begin
      e_flag[c] = fl; e_amt[c] = am; e_st[c] = st; e_busy[c] = 1'b1;
    end
  endtask

  task automatic abort_at(input int c);
    e_busy[c] = 1'b1;
    e_to[c]   = 1'b1;
    last_cyc  = c + 1;
  endtask

  // Responder drives handshake_in high from cycle up, low rb cycles after cmd_flag falls
  task automatic predict_dispense(input logic [1:0] amt, input int up, input int rb);
    int s, a, c, r, npass;
    clear_exp();
    hs_up = up; hs_dn = NEVER;
    s = 1; r = -1; npass = 1;
`ifdef HS_RETRY_EN
    npass = 2;
`endif
    for (int p = 0; p < npass; p++) begin
      c = first_lvl(s + SETUP - 1, s + TOUT - 1, 1'b0);
      if (c < 0) begin
        fill(s, s + TOUT - 1, 1'b0, amt, 3'b000);
        abort_at(s + TOUT);
        return;
      end
      fill(s, c, 1'b0, amt, 3'b000);
      a = c + 1;
      c = first_lvl(a, a + TOUT - 1, 1'b1);
      if (c >= 0) begin
        fill(a, c, 1'b1, amt, 3'b000);
        r = c + 1;
        break;
      end
      fill(a, a + TOUT - 1, 1'b1, amt, 3'b000);
      s = a + TOUT;
    end
    if (r < 0) begin
      abort_at(s);
      return;
    end
    hs_dn = r + rb;
    c = first_lvl(r, r + TOUT - 1, 1'b0);
    if (c < 0) begin
      fill(r, r + TOUT - 1, 1'b0, amt, 3'b000);
      e_to[r + TOUT] = 1'b1;
      last_cyc = r + TOUT;
    end else begin
      fill(r, c, 1'b0, amt, 3'b000);
      e_done[c + 1] = 1'b1;
      last_cyc = c + 1;
    end
  endtask

  task automatic predict_test(input logic [2:0] code);
    clear_exp();
    hs_up = NEVER; hs_dn = NEVER;
    fill(1, HOLD, 1'b0, 2'b00, code);
    e_done[HOLD + 1] = 1'b1;
    last_cyc = HOLD + 1;
  endtask

  // ---------------- stimulus ----------------
  task automatic run_txn(input logic mode, input logic [2:0] code, input logic [1:0] amt,
                         input int poke, input int stop);
    int hi;
    hi = (stop < last_cyc + 1) ? stop : last_cyc + 1;
    @(posedge clk); #1;
    req_valid = 1'b1; req_mode = mode; req_test = code; req_amount = amt;
    @(negedge clk);
    check_cycle(0);
    for (int c = 1; c <= hi; c++) begin
      @(posedge clk); #1;
      req_valid = (c == poke);
      if (c == poke) begin
        req_mode = ~mode; req_test = 3'b111; req_amount = ~amt;
      end
      handshake_in = (c >= hs_up) && (c < hs_dn);
      @(negedge clk);
      check_cycle(c);
    end
    if (stop > last_cyc) begin
      @(posedge clk); #1;
      handshake_in = 1'b0;
      req_valid    = 1'b0;
      repeat (3) @(posedge clk);
    end
  endtask

  task automatic reset_midway(input string tag);
    #2 rst = 1'b1;
    #1 check_reset(tag);
    handshake_in = 1'b0;
    req_valid    = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  initial begin
    logic [1:0] amt;
    logic [2:0] code;
    int ra, rb;
    rst = 1'b1; req_valid = 1'b0; req_mode = 1'b0; req_test = 3'b000;
    req_amount = 2'b00; handshake_in = 1'b0;
    #3 check_reset("por");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);

    // Nominal dispense: response 20 cycles after flag, release 5 cycles after fall
    predict_dispense(2'b10, 1 + SETUP + 20, 5);
    run_txn(1'b1, 3'b000, 2'b10, 0, NEVER);

    // Test codes, including the all-zero and all-one codes
    predict_test(3'b101);
    run_txn(1'b0, 3'b101, 2'b11, 0, NEVER);
    predict_test(3'b000);
    run_txn(1'b0, 3'b000, 2'b00, 0, NEVER);
    predict_test(3'b111);
    run_txn(1'b0, 3'b111, 2'b01, 0, NEVER);

    // No response at all
    predict_dispense(2'b01, NEVER, 0);
    run_txn(1'b1, 3'b000, 2'b01, 0, NEVER);

    // Handshake stuck high from acceptance
    predict_dispense(2'b11, 1, 0);
    run_txn(1'b1, 3'b000, 2'b11, 0, NEVER);

    // Response seen in the last ASSERT cycle (with a request poked while busy), then one late
    predict_dispense(2'b10, 1 + SETUP + TOUT - 3, 3);
    run_txn(1'b1, 3'b000, 2'b10, 10, NEVER);
    predict_dispense(2'b10, 1 + SETUP + TOUT - 2, 3);
    run_txn(1'b1, 3'b000, 2'b10, 0, NEVER);

    // Release boundary: low seen in the last RELEASE cycle, then one late
    predict_dispense(2'b01, 1 + SETUP + 7, TOUT - 3);
    run_txn(1'b1, 3'b000, 2'b01, 0, NEVER);
    predict_dispense(2'b01, 1 + SETUP + 7, TOUT - 2);
    run_txn(1'b1, 3'b000, 2'b01, 0, NEVER);

    // Asynchronous reset mid-ASSERT and mid-TEST
    predict_dispense(2'b11, NEVER, 0);
    run_txn(1'b1, 3'b000, 2'b11, 0, 10);
    reset_midway("rst_assert");
    predict_test(3'b110);
    run_txn(1'b0, 3'b110, 2'b00, 0, 6);
    reset_midway("rst_test");

    // Randomized requests
    for (int i = 0; i < 14; i++) begin
      amt  = 2'($urandom_range(3, 0));
      code = 3'($urandom_range(7, 0));
      ra   = int'($urandom_range(70, 0));
      rb   = int'($urandom_range(70, 0));
      if ($urandom_range(3, 0) == 0) begin
        predict_test(code);
        run_txn(1'b0, code, amt, int'($urandom_range(HOLD - 1, 1)), NEVER);
      end else begin
        predict_dispense(amt, 1 + SETUP + ra, rb);
        run_txn(1'b1, code, amt, int'($urandom_range(SETUP, 1)), NEVER);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
